// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer.
// Holds the FSM state encoding and the default counter width.
package timer_pkg;

    localparam int TIMER_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/down_count_reg.sv
// Down-count register with async clear, sync load and decrement.
// is_one flags the terminal value so the FSM can expire without underflow.
module down_count_reg
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             is_one
);

    // Load wins over decrement; reset clears the count at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - WIDTH'(1);
        end
    end

    assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter timer with pause, abort and auto-reload.
// Pulses done for one cycle on each expiry; a zero load expires at once.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    timer_state_t     state;
    timer_state_t     state_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic [WIDTH-1:0] load_val;
    logic             load;
    logic             dec;
    logic             done_d;
    logic             is_one;

    down_count_reg #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .count    (count),
        .is_one   (is_one)
    );

    // Next-state decode: abort > start > pause > decrement/expiry.
    always_comb begin
        state_d  = state;
        reload_d = reload_q;
        load     = 1'b0;
        load_val = '0;
        dec      = 1'b0;
        done_d   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            load    = 1'b1;
        end else if (start) begin
            load     = 1'b1;
            load_val = load_data;
            reload_d = load_data;
            if (load_data != '0) begin
                state_d = RUN;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (state == RUN && !pause) begin
            if (is_one) begin
                done_d = 1'b1;
                load   = 1'b1;
                if (auto_reload) begin
                    load_val = reload_q;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                dec = 1'b1;
            end
        end
    end

    // State, reload value and the registered done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            reload_q <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            reload_q <= reload_d;
            done     <= done_d;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer.
// Vector table plus hand sequences for reset and auto-reload.
module tb_countdown_timer;

    typedef struct {
        logic       start;
        logic       abort;
        logic       pause;
        logic       auto_reload;
        logic [3:0] load_data;
        logic [3:0] exp_count;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       pause;
    logic       auto_reload;
    logic [3:0] load_data;
    logic [3:0] count;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    countdown_timer #(
        .WIDTH(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .pause       (pause),
        .auto_reload (auto_reload),
        .load_data   (load_data),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic s, input logic a, input logic p,
                       input logic r, input logic [3:0] ld,
                       input logic [3:0] ec, input logic eb,
                       input logic ed);
        vec_t v;
        v.start = s; v.abort = a; v.pause = p; v.auto_reload = r;
        v.load_data = ld; v.exp_count = ec;
        v.exp_busy = eb; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] ec,
                         input logic eb, input logic ed);
        n_tests++;
        if (count !== ec || busy !== eb || done !== ed) begin
            n_fail++;
            $display("FAIL %s: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                     name, count, busy, done, ec, eb, ed);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic p,
                         input logic r, input logic [3:0] ld);
        @(negedge clk);
        start = s; abort = a; pause = p; auto_reload = r; load_data = ld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        start = 0; abort = 0; pause = 0; auto_reload = 0; load_data = 0;
        #2;
        check("reset", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // one-shot 5
        add(1,0,0,0,5, 5,1,0);
        add(0,0,0,0,0, 4,1,0);
        add(0,0,0,0,0, 3,1,0);
        add(0,0,0,0,0, 2,1,0);
        add(0,0,0,0,0, 1,1,0);
        add(0,0,0,0,0, 0,0,1);
        add(0,0,0,0,0, 0,0,0);
        // zero load
        add(1,0,0,0,0, 0,0,1);
        add(0,0,0,0,0, 0,0,0);
        // pause 3 cycles at count 2
        add(1,0,0,0,4, 4,1,0);
        add(0,0,0,0,0, 3,1,0);
        add(0,0,0,0,0, 2,1,0);
        add(0,0,1,0,0, 2,1,0);
        add(0,0,1,0,0, 2,1,0);
        add(0,0,1,0,0, 2,1,0);
        add(0,0,0,0,0, 1,1,0);
        add(0,0,0,0,0, 0,0,1);
        // pause at terminal defers expiry
        add(1,0,0,0,4, 4,1,0);
        add(0,0,0,0,0, 3,1,0);
        add(0,0,0,0,0, 2,1,0);
        add(0,0,0,0,0, 1,1,0);
        add(0,0,1,1,0, 1,1,0);
        add(0,0,1,0,0, 1,1,0);
        add(0,0,0,0,0, 0,0,1);
        // abort beats start
        add(1,0,0,0,5, 5,1,0);
        add(0,0,0,0,0, 4,1,0);
        add(0,0,0,0,0, 3,1,0);
        add(1,1,0,0,7, 0,0,0);
        add(0,0,0,0,0, 0,0,0);
        // restart at terminal: no done
        add(1,0,0,0,3, 3,1,0);
        add(0,0,0,0,0, 2,1,0);
        add(0,0,0,0,0, 1,1,0);
        add(1,0,0,0,6, 6,1,0);
        add(0,0,0,0,0, 5,1,0);
        add(0,1,0,0,0, 0,0,0);
        // start beats pause; idle ignores pause
        add(1,0,1,0,2, 2,1,0);
        add(0,0,0,0,0, 1,1,0);
        add(0,0,0,0,0, 0,0,1);
        add(0,0,1,1,0, 0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].abort, vecs[i].pause,
                  vecs[i].auto_reload, vecs[i].load_data);
            check($sformatf("vec%0d", i), vecs[i].exp_count,
                  vecs[i].exp_busy, vecs[i].exp_done);
        end

        // reset mid-run
        drive(1,0,0,0,9);
        drive(0,0,0,0,0);
        drive(0,0,0,0,0);
        drive(0,0,0,0,0);
        check("pre_reset", 4'd6, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        check("async_reset", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0,0,0,0,0);
            check($sformatf("post_reset%0d", k), 4'd0, 1'b0, 1'b0);
        end

        // auto-reload 15, then drop auto_reload
        drive(1,0,0,1,15);
        check("ar_start", 4'd15, 1'b1, 1'b0);
        for (int k = 1; k <= 45; k++) begin
            drive(0,0,0,(k <= 30) ? 1'b1 : 1'b0,0);
            if (k == 45)
                check("ar_final", 4'd0, 1'b0, 1'b1);
            else
                check($sformatf("ar%0d", k), 4'(15 - (k % 15)),
                      1'b1, (k % 15) == 0);
        end
        drive(0,0,0,0,0);
        check("ar_idle", 4'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
